// File: rtl/sandbox_pkg.sv
// Shared types and constants for the sandbox dispatcher: FSM state encodings,
// control-field position and the drop counter ceiling.
package sandbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELIVER,
        ACK
    } disp_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    localparam int TARGET_LSB = 0;
    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around, as both a one-hot vector and an index.
module rr_arbiter #(
    parameter int NUM_PROC = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_PROC-1:0] request,
    input  logic [IDX_W-1:0]    pointer,
    output logic [NUM_PROC-1:0] grant,
    output logic [IDX_W-1:0]    index
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_PROC; k++) begin
            cand = (int'(pointer) + k) % NUM_PROC;
            if (!found && request[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sandbox_dispatcher.sv
// Routes host words to one of NUM_PROC sandbox processes by control-byte target
// and round-robin multiplexes the processes' transmit requests onto the host.
module sandbox_dispatcher
    import sandbox_pkg::*;
#(
    parameter int NUM_PROC       = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    masterClock,
    input  logic                    reset,
    input  logic                    dataReceived,
    input  logic [7:0]              control,
    input  logic [31:0]             inputData,
    output logic                    clearDR,
    output logic [NUM_PROC-1:0]     procDataReceived,
    output logic [7:0]              procControl,
    output logic [31:0]             procInputData,
    input  logic [NUM_PROC-1:0]     procClearDR,
    input  logic [NUM_PROC-1:0]     procTransmitData,
    input  logic [32*NUM_PROC-1:0]  procOutputData,
    output logic                    transmitData,
    output logic [31:0]             outputData,
    input  logic                    txDone,
    output logic [7:0]              dropCount
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    disp_state_t         disp_state, disp_next;
    logic [ID_W-1:0]     target, new_target;
    logic [CNT_W-1:0]    deliver_count;
    logic                aborted, accept, drop_event, clear_sel, in_range;

    tx_state_t           tx_state, tx_next;
    logic [ID_W-1:0]     pointer, grant_idx, arb_idx;
    logic [NUM_PROC-1:0] served, served_set, grant_q, arb_grant, eligible;
    logic                load_grant;
    logic [31:0]         arb_word;

    assign new_target = control[TARGET_LSB +: ID_W];
    assign in_range   = int'(new_target) < NUM_PROC;

    always_comb begin
        clear_sel = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (int'(target) == i) clear_sel = procClearDR[i];
        end
    end

    // A timeout and a clear in the same cycle resolve as a clean delivery.
    always_comb begin
        disp_next        = disp_state;
        accept           = 1'b0;
        drop_event       = 1'b0;
        procDataReceived = '0;
        clearDR          = 1'b0;
        unique case (disp_state)
            IDLE: begin
                if (dataReceived) begin
                    accept = 1'b1;
                    if (in_range) begin
                        disp_next = DELIVER;
                    end else begin
                        disp_next  = ACK;
                        drop_event = 1'b1;
                    end
                end
            end
            DELIVER: begin
                for (int i = 0; i < NUM_PROC; i++) begin
                    if (int'(target) == i) procDataReceived[i] = 1'b1;
                end
                if (clear_sel) begin
                    disp_next = ACK;
                end else if (deliver_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    disp_next  = ACK;
                    drop_event = 1'b1;
                end
            end
            ACK: begin
                clearDR = 1'b1;
                if (!dataReceived && (!clear_sel || aborted)) disp_next = IDLE;
            end
            default: disp_next = IDLE;
        endcase
    end

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            disp_state    <= IDLE;
            target        <= '0;
            procControl   <= '0;
            procInputData <= '0;
            deliver_count <= '0;
            aborted       <= 1'b0;
            dropCount     <= '0;
        end else begin
            disp_state <= disp_next;
            if (accept) begin
                target        <= new_target;
                procControl   <= control;
                procInputData <= inputData;
            end
            deliver_count <= (disp_state == DELIVER) ? deliver_count + 1'b1 : '0;
            if (drop_event) begin
                aborted <= 1'b1;
            end else if (disp_state == IDLE) begin
                aborted <= 1'b0;
            end
            if (drop_event && dropCount != DROP_MAX) dropCount <= dropCount + 8'd1;
        end
    end

    // Already-served processes stay masked until they drop their request level.
    assign eligible = procTransmitData & ~served;

    rr_arbiter #(
        .NUM_PROC (NUM_PROC),
        .IDX_W    (ID_W)
    ) u_arbiter (
        .request (eligible),
        .pointer (pointer),
        .grant   (arb_grant),
        .index   (arb_idx)
    );

    always_comb begin
        arb_word = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (int'(arb_idx) == i) arb_word = procOutputData[32*i +: 32];
        end
    end

    always_comb begin
        tx_next      = tx_state;
        load_grant   = 1'b0;
        served_set   = '0;
        transmitData = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (|eligible) begin
                    load_grant = 1'b1;
                    tx_next    = TX_SEND;
                end
            end
            TX_SEND: begin
                transmitData = 1'b1;
                if (txDone) begin
                    served_set = grant_q;
                    tx_next    = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            served     <= '0;
            grant_q    <= '0;
            grant_idx  <= '0;
            outputData <= '0;
            pointer    <= '0;
        end else begin
            tx_state <= tx_next;
            served   <= (served | served_set) & procTransmitData;
            if (load_grant) begin
                grant_q    <= arb_grant;
                grant_idx  <= arb_idx;
                outputData <= arb_word;
            end
            if (|served_set) begin
                pointer <= (int'(grant_idx) == NUM_PROC - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/sandbox_dispatcher.md
# sandbox_dispatcher

Routes host words from the single receive channel to one of `NUM_PROC` sandbox processes, selected by the control byte. It also round-robin arbitrates the processes' transmit requests onto the single host transmitter. It sits between the host link receiver/transmitter and the array of sandbox processes. Toward the processes it reproduces the dataReceived/clearDR and transmitData handshakes, so each process is unchanged.

## Interface
- `NUM_PROC`, 4: number of attached processes (2..8).
- `ID_W`, 2: width of the target field, `control[ID_W-1:0]`; ≥ clog2(NUM_PROC).
- `TIMEOUT_CYCLES`, 1024: maximum cycles a process may take to assert clearDR.

Ports:
- `masterClock` in 1: single operating clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `dataReceived` in 1: host word available (level).
- `control` in 8: received control byte.
- `inputData` in 32: received data word.
- `clearDR` out 1: acknowledge to receiver.
- `procDataReceived` out NUM_PROC: per-process data-received.
- `procControl` out 8, `procInputData` out 32: latched copy, broadcast to all processes.
- `procClearDR` in NUM_PROC: per-process clearDR.
- `procTransmitData` in NUM_PROC: per-process transmit request (level).
- `procOutputData` in 32·NUM_PROC: process i occupies bits [32i+31:32i].
- `transmitData` out 1: request to transmitter.
- `outputData` out 32: word to transmit.
- `txDone` in 1: one-cycle pulse, word sent.
- `dropCount` out 8: saturating count of dropped or aborted words.

## Operation
- All outputs reset to 0; both FSMs reset to IDLE; RR pointer reset to 0; `served` reset to 0.
- **Dispatch FSM:**
  - IDLE: on `dataReceived=1`:
    - Latch `control`/`inputData` and target t = `control[ID_W-1:0]`.
    - If t < NUM_PROC, go to DELIVER.
    - Otherwise go to ACK and increment `dropCount`.
  - DELIVER:
    - `procDataReceived[t]=1`; cycle counter runs.
    - On `procClearDR[t]=1`, go to ACK.
    - If the counter reaches TIMEOUT_CYCLES−1, go to ACK and increment `dropCount` (abort).
  - ACK:
    - `procDataReceived[t]=0`; `clearDR=1`.
    - Stay until `dataReceived=0` AND (`procClearDR[t]=0` or abort/drop), then go to IDLE with `clearDR=0`.
- Only one word is in flight at a time.
- `procControl`/`procInputData` hold the last latched value until the next IDLE accept.
- **Transmit FSM:**
  - TX_IDLE: eligible = `procTransmitData & ~served`. If eligible is non-zero, grant g = the first eligible index at or after the pointer (wrapping), latch `procOutputData[g]`, and go to TX_SEND.
  - TX_SEND: `transmitData=1`; wait for `txDone`. Then set `served[g]`, set pointer = (g+1) mod NUM_PROC, deassert `transmitData`, and go to TX_IDLE.
  - `served[i]` clears in any cycle where `procTransmitData[i]=0`, so a held level request is sent exactly once.
- The two FSMs are independent; dispatch and transmit to different or the same process may overlap.
- `dropCount` saturates at 8'hFF.

## Timing
- Accept latency: `dataReceived` sampled at edge N → `procDataReceived[t]` high after edge N+1.
- `procClearDR[t]` sampled high at edge M → `clearDR` high after M+1, and `procDataReceived[t]` low after M+1.
- ACK exit: `clearDR` low the cycle after both release conditions are sampled.
- Timeout: with no clear, ACK is entered after exactly TIMEOUT_CYCLES cycles in DELIVER.
- TX grant: request sampled at edge K → `transmitData` high after K+1, with `outputData` stable for the whole TX_SEND.
- `txDone` sampled at edge J → `transmitData` low after J+1. The earliest next grant is 2 cycles after `txDone`.
- `txDone` outside TX_SEND is ignored.
- Same-cycle `procClearDR[t]` and timeout expiry: clear wins, no drop counted.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronous); any in-flight word is lost without a count.

## Structure
- Package `sandbox_pkg`:
  - dispatch state enum (IDLE, DELIVER, ACK) and TX state enum (TX_IDLE, TX_SEND);
  - constant for the control target-field LSB (0);
  - `DROP_MAX` = 8'hFF.
- Sub-module `rr_arbiter`: inputs request vector and pointer; outputs one-hot grant and encoded index; combinational, parameterised by NUM_PROC.
- Dispatch FSM, TX FSM and counters live in the top module.

## Test plan
- Word with control=8'h02, data=32'hDEADBEEF:
  - `procDataReceived`=4'b0100 and `procInputData`=DEADBEEF one cycle after the accept;
  - `clearDR` rises one cycle after `procClearDR[2]`;
  - returns to IDLE after `dataReceived` falls.
- With NUM_PROC=3, control=8'h03: no `procDataReceived`, `clearDR` asserts, `dropCount`=1.
- Process 1 never clears, TIMEOUT_CYCLES=16: `procDataReceived[1]` high exactly 16 cycles, then `clearDR`, `dropCount`=1.
- Processes 0, 2 and 3 request simultaneously with distinct words and `txDone` 3 cycles after each `transmitData`: words go out in order 0, 2, 3; each is sent once while requests are held.
- Process 0 drops and re-raises its request after being served: it is sent again, and the pointer rotation is honoured against a pending request from 1.
- Reset pulse asserted in DELIVER and in TX_SEND: all outputs 0 within the same cycle; a fresh word after release dispatches normally.
